reg_write_arbiter: RTL
======================

Name: reg_write_arbiter

Overview:
Shares write access to a bank of NREG 8-bit enable-loaded registers among NREQ requesters. Each requester presents an address and data under a req/gnt handshake. The arbiter selects one winner round-robin, then drives the shared data bus and a one-hot load-enable vector into the register bank for exactly one clock. Sits between the requester logic and the register bank; the registers themselves stay simple reset/enable/data flops.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, register data width
NREG, 4, number of registers in bank (power of 2, >=2)
AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_  input  1  reset, asynchronous, active-low
req  input  NREQ  per-requester write request, level, held until gnt seen
req_addr  input  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_data  input  NREQ*DW  packed data, requester i at [i*DW +: DW]
gnt  output  NREQ  one-hot grant pulse, 1 cycle, registered
reg_data  output  DW  data to register bank, registered
reg_enable  output  NREG  one-hot load enable to register bank, registered
busy  output  1  high while in WRITE state

Behaviour:
- Reset: rst_ asynchronous, active-low; clock clk. While rst_=0: gnt=0, reg_data=0, reg_enable=0, busy=0, state=IDLE, rr pointer=0.
- FSM has two states, IDLE and WRITE.
- IDLE, req==0: stay IDLE, all outputs 0 (reg_data holds last value).
- IDLE, req!=0: winner = first set req bit searching upward from rr pointer, wrapping at NREQ-1 -> 0. On the clock edge:
  - gnt[winner]=1
  - reg_enable[req_addr[winner]]=1
  - reg_data=req_data[winner]
  - rr pointer = (winner+1) mod NREQ
  - busy=1, go to WRITE
- WRITE: lasts exactly 1 cycle. On the next edge gnt=0, reg_enable=0, busy=0, go to IDLE. req is not sampled in WRITE.
- Latency: req rise -> gnt/reg_enable on the next edge. The register bank captures on the edge after that.
- Throughput: max one write per 2 cycles.
- Handshake: a requester deasserts req (or presents a new addr/data) in the cycle it sees gnt. A req still high in IDLE after gnt is treated as a new request.
- addr/data are sampled only on the IDLE->WRITE edge. Changes at other times have no effect.
- Simultaneous requests: exactly one gnt bit. Losers keep req and are served in rotation order. No requester waits more than NREQ grants.
- Pointer wrap: winner=NREQ-1 sets pointer to 0.
- reg_enable is always one-hot or zero. gnt is always one-hot or zero. gnt and reg_enable are asserted in the same cycles.
- Reset mid-WRITE: outputs clear immediately and asynchronously; the in-flight write is dropped. The requester must re-request after reset.
- req_addr >= NREG cannot occur (NREG power of 2).

Optional Feature:
REG_WRITE_ARB_PRIO_EN
- Defined: requester 0 has fixed top priority. If req[0]=1 in IDLE it wins regardless of the rr pointer, and the pointer is not updated. Round-robin applies only among requesters 1..NREQ-1 when req[0]=0.
- Undefined: pure round-robin over all NREQ requesters as described above.

Test Plan:
- Reset: drive rst_=0 mid-WRITE (gnt=0001, reg_enable=0100) -> gnt, reg_enable, busy go to 0 without a clock edge; after release, state=IDLE and pointer=0.
- Single write: req=0010, addr1=3, data1=8'hA5 -> next edge gnt=0010, reg_enable=1000, reg_data=A5, busy=1. One cycle later all three are 0.
- Contention: req=1111 held, each requester drops req on its gnt -> grants in order 0001, 0010, 0100, 1000, spaced 2 cycles apart, no gap cycles with gnt=0 beyond the WRITE/IDLE alternation.
- Wrap/fairness: pointer=3 via a prior grant to 2, then req=1001 -> gnt=1000 first, then 0001; pointer ends at 1.
- Persistent req: req=0100 held 6 cycles, data changes each cycle -> gnt pulses on cycles 1, 3, 5, each latching the data present on its IDLE edge.
- With REG_WRITE_ARB_PRIO_EN defined, pointer=2, req=0101 -> gnt=0001 first, pointer still 2, then gnt=0100.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter granting NREQ requesters single-cycle
// write access to a bank of NREG enable-loaded registers.
// Optional feature macro: REG_WRITE_ARB_PRIO_EN (requester 0 gets fixed top
// priority; round-robin then applies only among requesters 1..NREQ-1).
module reg_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int NREG = 4,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [DW-1:0]        reg_data,
    output logic [NREG-1:0]      reg_enable,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [NREQ-1:0]   cand;
    logic              found;
    logic [PW-1:0]     win;
    logic [AW-1:0]     win_addr;
    logic [NREQ-1:0]   gnt_nxt;
    logic [NREG-1:0]   enable_nxt;
    logic [DW-1:0]     data_nxt;
    int                idx;

    // Pick the first requesting candidate at or above the pointer, wrapping.
    always_comb begin
        cand  = req;
`ifdef REG_WRITE_ARB_PRIO_EN
        cand[0] = 1'b0;
`endif
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
`ifdef REG_WRITE_ARB_PRIO_EN
        // Requester 0 overrides rotation whenever it asks.
        if (req[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
        win_addr = req_addr[int'(win)*AW +: AW];
    end

    // Next-state, pointer and next-output decode; req is ignored in WRITE.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_nxt    = '0;
        enable_nxt = '0;
        data_nxt   = reg_data;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt            = WRITE;
                    gnt_nxt[win]         = 1'b1;
                    enable_nxt[win_addr] = 1'b1;
                    data_nxt             = req_data[int'(win)*DW +: DW];
`ifdef REG_WRITE_ARB_PRIO_EN
                    if (!req[0]) begin
                        ptr_nxt = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
                    end
`else
                    ptr_nxt = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
`endif
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and rotation pointer registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Registered outputs toward the requesters and the register bank.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            gnt        <= '0;
            reg_enable <= '0;
            reg_data   <= '0;
        end else begin
            gnt        <= gnt_nxt;
            reg_enable <= enable_nxt;
            reg_data   <= data_nxt;
        end
    end

    assign busy = (state == WRITE);

endmodule
